seq_mult_unit: RTL

- Sequential unsigned shift-add multiplier for the accumulator CPU datapath.
- Sits directly downstream of the control FSM's MULT execute states.
- Starts on a one-cycle load strobe, with ACC and MDR values as operands.
- Produces a full-width product plus a done pulse, and holds the result until the next load.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/seq_mult_unit.sv | 80 ++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, multiplier states, default width.
package cpu_pkg;

  localparam int unsigned OP_ADD   = 1;
  localparam int unsigned OP_OR    = 2;
  localparam int unsigned OP_JUMP  = 3;
  localparam int unsigned OP_JUMPZ = 4;
  localparam int unsigned OP_LOAD  = 5;
  localparam int unsigned OP_STORE = 6;
  localparam int unsigned OP_MULT  = 9;

  localparam int MULT_W = 8;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } msState_t;

endpackage

// File: rtl/seq_mult_unit.sv
// Sequential unsigned shift-add multiplier: W iterations per product, one-cycle done pulse.
// Handshake: a start is accepted when mult_ld=1 on a rising edge in IDLE or DONE;
// mult_done pulses for one cycle when product is valid, and product holds until the next accepted start.
module seq_mult_unit
  import cpu_pkg::*;
#(
  parameter int W  = MULT_W,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult_ld,
  input  logic [W-1:0]     opa,
  input  logic [W-1:0]     opb,
  output logic [2*W-1:0]   product,
  output logic [W-1:0]     result,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             mult_done,
  output msState_t         dbgState
);

  msState_t      state;
  msState_t      stateNext;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] count;
  logic [W:0]    sum;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MS_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      MS_IDLE: if (mult_ld) stateNext = MS_RUN;
      MS_RUN:  if (count == CW'(1)) stateNext = MS_DONE;
      MS_DONE: stateNext = mult_ld ? MS_RUN : MS_IDLE;
      default: stateNext = MS_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == MS_RUN);
    mult_done = (state == MS_DONE);
    accept    = mult_ld && ((state == MS_IDLE) || (state == MS_DONE));
  end

  // Carry out of the upper-half add lands in product[2W-1] after the shift, so nothing is lost.
  assign sum = {1'b0, product[2*W-1:W]} + {1'b0, mcand};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else if (accept) begin
      product <= '0;
      mcand   <= opa;
      mplier  <= opb;
      count   <= CW'(W);
    end else if (state == MS_RUN) begin
      if (mplier[0]) product <= {sum, product[W-1:1]};
      else           product <= {1'b0, product[2*W-1:1]};
      mplier <= {1'b0, mplier[W-1:1]};
      count  <= count - CW'(1);
    end
  end

  assign result   = product[W-1:0];
  assign ovf      = |product[2*W-1:W];
  assign zero     = (result == '0);
  assign dbgState = state;

endmodule
